// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, two-state fetch FSM, hold buffer and IF/ID register.
// Optional macro IF_BRANCH_FLUSH_EN squashes the instruction following a taken redirect.
module if_fetch_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic        o_dbg_hold
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic [31:0] r_buf;
    logic        r_redir_vld;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc_plus4;
    logic        w_req;
    logic        w_done;
    logic        w_src_redir;
    logic [31:0] w_src_target;
    logic [31:0] w_next_pc;
    logic        w_kill;
    logic        w_adv;
    logic        w_bubble;
    logic        w_capture;
    logic        w_latch;
    logic [31:0] w_word;

    // Handshake: a fetch completes on a rising edge where imem_req=1 and imem_ready=1;
    // imem_req is forced low while clrn=0 so a late ready during reset is ignored.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_req        = (r_state == S_FETCH) && clrn;
    assign w_done       = w_req && imem_ready;
    assign w_src_redir  = (pcsource == 2'b01) || (pcsource == 2'b11);
    assign w_src_target = (pcsource == 2'b11) ? jpc : bpc;
    assign w_next_pc    = r_redir_vld ? r_redir_pc :
                          (w_src_redir ? w_src_target : w_pc_plus4);

    assign imem_addr  = r_pc;
    assign imem_req   = w_req;
    assign pc         = r_pc;
    assign pc4        = r_pc4;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign o_dbg_hold = (r_state == S_HOLD);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_bubble    = 1'b0;
        w_capture   = 1'b0;
        w_latch     = 1'b0;
        w_word      = imem_rdata;
        case (r_state)
            S_FETCH: begin
                if (w_done) begin
                    if (wpcir) begin
                        w_adv = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (wpcir) begin
                    w_bubble = 1'b1;
                    w_latch  = w_src_redir;
                end
            end
            S_HOLD: begin
                w_word = r_buf;
                if (wpcir) begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

`ifdef IF_BRANCH_FLUSH_EN
    logic r_squash;

    // Kept set from the moment a redirect is latched until the wrong-path word finally loads.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)        r_squash <= 1'b0;
        else if (w_adv)   r_squash <= 1'b0;
        else if (w_latch) r_squash <= 1'b1;
    end

    assign w_kill = r_squash || w_src_redir;
`else
    assign w_kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc         <= 32'd0;
            r_pc4        <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_buf        <= 32'd0;
            r_redir_vld  <= 1'b0;
            r_redir_pc   <= 32'd0;
        end else begin
            if (w_adv) begin
                r_pc         <= w_next_pc;
                r_pc4        <= w_pc_plus4;
                r_inst       <= w_kill ? 32'd0 : w_word;
                r_inst_valid <= !w_kill;
                r_redir_vld  <= 1'b0;
            end else if (w_bubble) begin
                r_inst       <= 32'd0;
                r_inst_valid <= 1'b0;
                if (w_latch) begin
                    r_redir_vld <= 1'b1;
                    r_redir_pc  <= w_src_target;
                end
            end
            if (w_capture) r_buf <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a random wait-state run.
module tb_if_fetch_stage;

`ifdef IF_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic        wpcir;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        o_dbg_hold;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc4, inst, inst_valid, pc, imem_req}
    logic [97:0] exp_q[$];

    if_fetch_stage dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .wpcir      (wpcir),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .o_dbg_hold (o_dbg_hold)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // driver: apply one cycle of stimulus, record expectation, compare after the edge
    task automatic step(input logic rdy, input logic wp, input logic [1:0] src,
                        input logic [31:0] tgt, input logic [31:0] e_pc4,
                        input logic [31:0] e_inst, input logic e_valid,
                        input logic [31:0] e_pc, input logic e_req);
        logic [97:0] e;
        imem_ready = rdy;
        wpcir      = wp;
        pcsource   = src;
        bpc        = tgt;
        jpc        = tgt;
        exp_q.push_back({e_pc4, e_inst, e_valid, e_pc, e_req});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("pc4",        pc4,                 e[97:66]);
        check_eq("inst",       inst,                e[65:34]);
        check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, e[33]});
        check_eq("pc",         pc,                  e[32:1]);
        check_eq("imem_addr",  imem_addr,           e[32:1]);
        check_eq("imem_req",   {31'd0, imem_req},   {31'd0, e[0]});
        check_eq("hold_state", {31'd0, o_dbg_hold}, {31'd0, !e[0]});
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"},    pc,                 32'd0);
        check_eq({tag, "_pc4"},   pc4,                32'd0);
        check_eq({tag, "_inst"},  inst,               32'd0);
        check_eq({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check_eq({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check_eq({tag, "_addr"},  imem_addr,          32'd0);
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_pc4;
        logic        rdy;
        clrn       = 1'b0;
        imem_ready = 1'b1;
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        bpc        = 32'd0;
        jpc        = 32'd0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check_eq("post_rst_req",  {31'd0, imem_req}, 32'd1);
        check_eq("post_rst_addr", imem_addr,         32'd0);

        // sequential fetch, zero-wait
        step(1, 1, 2'b00, 0, 32'd4, mem_word(0), 1, 32'd4, 1);
        step(1, 1, 2'b00, 0, 32'd8, mem_word(4), 1, 32'd8, 1);
        // wait states at pc=8 load bubbles
        for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 0, 32'd8, 32'd0, 0, 32'd8, 1);
        step(1, 1, 2'b00, 0, 32'd12, mem_word(8), 1, 32'd12, 1);
        // completion while stalled -> HOLD; pcsource ignored while wpcir=0
        step(1, 0, 2'b00, 0, 32'd12, mem_word(8), 1, 32'd12, 0);
        step(1, 0, 2'b11, 32'h999, 32'd12, mem_word(8), 1, 32'd12, 0);
        step(0, 1, 2'b00, 0, 32'd16, mem_word(12), 1, 32'd16, 1);
        // branch presented during wait states -> pending redirect
        step(0, 1, 2'b01, 32'h100, 32'd16, 32'd0, 0, 32'd16, 1);
        step(0, 1, 2'b00, 0, 32'd16, 32'd0, 0, 32'd16, 1);
        step(1, 1, 2'b00, 0, 32'd20, FLUSH ? 32'd0 : mem_word(16), !FLUSH, 32'h100, 1);
        // direct jump to the top of the address space, then wrap
        step(1, 1, 2'b11, 32'hFFFF_FFFC, 32'h104, FLUSH ? 32'd0 : mem_word(32'h100), !FLUSH,
             32'hFFFF_FFFC, 1);
        step(1, 1, 2'b00, 0, 32'd0, mem_word(32'hFFFF_FFFC), 1, 32'd0, 1);
        // redirect taken from HOLD to an unaligned target
        step(1, 0, 2'b00, 0, 32'd0, mem_word(32'hFFFF_FFFC), 1, 32'd0, 0);
        step(0, 1, 2'b01, 32'h203, 32'd4, FLUSH ? 32'd0 : mem_word(0), !FLUSH, 32'h203, 1);
        step(0, 1, 2'b00, 0, 32'd4, 32'd0, 0, 32'h203, 1);

        // reset in the middle of a wait; late ready must be ignored
        clrn       = 1'b0;
        imem_ready = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_late_rdy");
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check_eq("rst2_req",  {31'd0, imem_req}, 32'd1);
        check_eq("rst2_addr", imem_addr,         32'd0);

        // random wait states on a sequential stream
        m_pc  = 32'd0;
        m_pc4 = 32'd0;
        for (int i = 0; i < 24; i++) begin
            rdy = ($urandom_range(0, 2) != 0);
            if (rdy) begin
                m_pc4 = m_pc + 32'd4;
                step(1, 1, 2'b00, 0, m_pc4, mem_word(m_pc), 1, m_pc + 32'd4, 1);
                m_pc = m_pc + 32'd4;
            end else begin
                step(0, 1, 2'b00, 0, m_pc4, 32'd0, 0, m_pc, 1);
            end
        end

        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
